// File: rtl/video_spi_slave.sv
// Responder end of the 3-wire video SPI link: decodes a R/W + address command, then either
// returns the holding register on sdio or captures a write word.
module video_spi_slave #(
    parameter int unsigned          CMD_BITS  = 8,
    parameter int unsigned          DATA_BITS = 16,
    parameter logic [DATA_BITS-1:0] IDLE_DATA = '0
) (
    input  logic                 sclk_full,
    input  logic                 n_rst,
    input  logic                 n_cs,
    inout  wire                  sdio,
    input  logic [DATA_BITS-1:0] rd_data,
    input  logic                 rd_valid,
    output logic [CMD_BITS-2:0]  rd_addr,
    output logic                 rd_ack,
    output logic [CMD_BITS-2:0]  wr_addr,
    output logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_valid,
    output logic                 frame_err
);

    localparam int unsigned FRAME_BITS = CMD_BITS + DATA_BITS;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(CMD_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCmd    = 3'd1;
    localparam logic [2:0] StRdData = 3'd2;
    localparam logic [2:0] StWrData = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    // Falling-edge domain: bit counter and input shifter. The R/W bit is never needed once
    // the frame is complete, so the shifter is one bit short of a full frame.
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_base;
    logic [FRAME_BITS-2:0] shin_q, shin_d;

    // Rising-edge domain
    logic [2:0]           state_q, state_d;
    logic                 clr_q, clr_d;
    logic                 oe_q, oe_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [CMD_BITS-2:0]  rd_addr_q, rd_addr_d;
    logic                 rd_ack_q, rd_ack_d;
    logic [CMD_BITS-2:0]  wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                 wr_valid_q, wr_valid_d;
    logic                 err_q, err_d;

    // The clear is requested on the first rising edge with n_cs high and applied on the
    // following falling edge, so the abort check still sees the final count of the frame.
    always_comb begin
        cnt_base = clr_q ? '0 : cnt_q;
        cnt_d    = cnt_base;
        shin_d   = shin_q;
        if (!n_cs && cnt_base != CNT_FULL) begin
            cnt_d  = cnt_base + 1'b1;
            shin_d = {shin_q[FRAME_BITS-3:0], sdio};
        end
    end

    always_ff @(negedge sclk_full or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            shin_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            shin_q <= shin_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_d      = n_cs;
        oe_d       = oe_q;
        out_d      = out_q;
        hold_d     = rd_valid ? rd_data : hold_q;
        rd_addr_d  = rd_addr_q;
        rd_ack_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        err_d      = 1'b0;
        if (n_cs) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            if (state_q != StIdle && cnt_q != '0 && cnt_q != CNT_FULL) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                StIdle: state_d = StCmd;
                StCmd: begin
                    if (cnt_q == CNT_CMD) begin
                        if (shin_q[CMD_BITS-1]) begin
                            // Snapshot uses the pre-load holding value on a same-cycle rd_valid.
                            state_d   = StRdData;
                            oe_d      = 1'b1;
                            out_d     = hold_q;
                            rd_ack_d  = 1'b1;
                            rd_addr_d = shin_q[CMD_BITS-2:0];
                        end else begin
                            state_d = StWrData;
                        end
                    end
                end
                StRdData: begin
                    if (cnt_q == CNT_FULL) begin
                        state_d = StDone;
                        oe_d    = 1'b0;
                    end else begin
                        out_d = {out_q[DATA_BITS-2:0], 1'b0};
                    end
                end
                StWrData: begin
                    if (cnt_q == CNT_FULL) begin
                        state_d    = StDone;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = shin_q[FRAME_BITS-2:DATA_BITS];
                        wr_data_d  = shin_q[DATA_BITS-1:0];
                    end
                end
                StDone: state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sclk_full or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            clr_q      <= 1'b0;
            oe_q       <= 1'b0;
            out_q      <= '0;
            hold_q     <= IDLE_DATA;
            rd_addr_q  <= '0;
            rd_ack_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            hold_q     <= hold_d;
            rd_addr_q  <= rd_addr_d;
            rd_ack_q   <= rd_ack_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
        end
    end

    // Bus is released the instant n_cs rises, without waiting for a clock edge.
    assign sdio      = (oe_q && !n_cs) ? out_q[DATA_BITS-1] : 1'bz;
    assign rd_addr   = rd_addr_q;
    assign rd_ack    = rd_ack_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_valid  = wr_valid_q;
    assign frame_err = err_q;

endmodule
